if_id_buf: RTL and testbench
============================

Name: if_id_buf

Overview:
- Parametrised fetch-to-decode buffer; successor to the single-entry IF/ID pipeline register.
- Holds up to DEPTH fetched {pc, inst} pairs in a circular FIFO between the fetch stage and the decode stage.
- Uses a valid/ready handshake on both sides, so fetch can run ahead while decode is stalled.
- Branch flush empties the buffer. When no valid entry is present, decode sees a bubble instruction.

Parameters:
- ADDR_W, 32, width of the pc field.
- INST_W, 32, width of the instruction field.
- DEPTH, 4, number of entries; must be a power of two, >= 2.
- BUBBLE_INST, 0, instruction value driven to decode when dec_valid_o = 0.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- fetch_valid_i  in  1  fetch presents a valid pc/inst pair.
- fetch_pc_i  in  ADDR_W  pc of the fetched instruction.
- fetch_inst_i  in  INST_W  fetched instruction.
- fetch_ready_o  out  1  buffer can accept a push this cycle.
- flush_i  in  1  branch/redirect taken in EX; discard all contents.
- dec_valid_o  out  1  head entry is valid.
- dec_pc_o  out  ADDR_W  pc of the head entry.
- dec_inst_o  out  INST_W  instruction of the head entry; BUBBLE_INST when invalid.
- dec_ready_i  in  1  decode consumes the head this cycle (decode not stalled).
- count_o  out  $clog2(DEPTH+1)  number of valid entries.
- empty_o  out  1  count_o == 0.
- full_o  out  1  count_o == DEPTH.

Behaviour:
- Reset (asynchronous, rst = 1):
  - wr_ptr = 0, rd_ptr = 0, count_o = 0.
  - dec_valid_o = 0, dec_pc_o = 0, dec_inst_o = BUBBLE_INST.
  - fetch_ready_o = 1, empty_o = 1, full_o = 0.
  - Reset mid-operation discards all entries immediately.
- Handshakes:
  - push = fetch_valid_i & fetch_ready_o.
  - pop = dec_valid_o & dec_ready_i.
- Flow-control outputs:
  - fetch_ready_o = !full_o. It is a registered-state function, not combinational from dec_ready_i.
  - When full, a same-cycle pop does NOT allow a push; the push is accepted the following cycle.
- Storage and pointers:
  - Push writes {fetch_pc_i, fetch_inst_i} at wr_ptr, then wr_ptr increments.
  - Pop increments rd_ptr.
  - Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- count_o update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged.
  - neither: unchanged.
- Decode outputs (first-word fall-through from registered state):
  - dec_valid_o = (count_o != 0).
  - dec_pc_o = mem[rd_ptr].pc when valid; otherwise holds the last driven pc.
  - dec_inst_o = mem[rd_ptr].inst when valid, else BUBBLE_INST.
  - Latency: an entry pushed in cycle N is visible on the dec_* outputs in cycle N+1. There is no combinational fetch-to-decode path.
- Stall: dec_ready_i = 0 holds the head entry and all dec_* outputs stable. Fetch may keep pushing until full.
- Flush (highest priority):
  - On the edge where flush_i = 1: rd_ptr and wr_ptr return to 0 and count_o becomes 0.
  - A same-cycle push is dropped and a same-cycle pop has no further effect.
  - Next cycle: dec_valid_o = 0 and dec_inst_o = BUBBLE_INST.
  - Pushes resume the cycle after flush_i is deasserted.
- Empty: a pop cannot occur because dec_valid_o = 0; dec_ready_i is ignored.
- Full: fetch_ready_o = 0 and fetch_valid_i is ignored.
- Storage contents are not reset; only pointers and count are.

Test Plan:
- Reset then idle: after rst is released, dec_valid_o = 0, dec_inst_o = BUBBLE_INST, count_o = 0, fetch_ready_o = 1, empty_o = 1.
- Single pass-through: push pc = 0x100, inst = 0x00500093 in cycle N with dec_ready_i = 1. Required: in cycle N+1, dec_valid_o = 1 with that pc/inst; in cycle N+2, count_o = 0 and dec_inst_o = BUBBLE_INST.
- Fill under stall (DEPTH = 4): with dec_ready_i = 0, push pc = 0x0, 0x4, 0x8, 0xC. Required: count_o = 4, full_o = 1, fetch_ready_o = 0, and a fifth push is ignored. Then set dec_ready_i = 1: outputs 0x0, 0x4, 0x8, 0xC appear in order, one per cycle.
- Full with simultaneous pop: at count_o = 4, assert dec_ready_i = 1 and fetch_valid_i = 1. Required: count_o = 3 next cycle (push rejected), then the push is accepted and count returns to 4.
- Wrap-around: stream 10 instructions with continuous push and pop over DEPTH = 4. Required: pc order preserved across pointer wrap, and count_o never exceeds 1 in steady state.
- Flush with concurrent push: at count_o = 3, assert flush_i = 1 and fetch_valid_i = 1 in the same cycle. Required: next cycle count_o = 0, dec_valid_o = 0, dec_inst_o = BUBBLE_INST, and the concurrent entry never appears. Also assert rst mid-stream and confirm it produces the same empty state asynchronously.

Source files
------------

// File: rtl/if_id_buf.sv
// Fetch-to-decode FIFO of {pc, inst} pairs; first-word fall-through, one-cycle push-to-decode latency.
// Backpressure: fetch_ready_o depends only on registered fullness; flush and reset empty the buffer.
module if_id_buf #(
   parameter int                ADDR_W      = 32,
   parameter int                INST_W      = 32,
   parameter int                DEPTH       = 4,
   parameter logic [INST_W-1:0] BUBBLE_INST = '0
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         fetch_valid_i,
   input  logic [ADDR_W-1:0]            fetch_pc_i,
   input  logic [INST_W-1:0]            fetch_inst_i,
   output logic                         fetch_ready_o,
   input  logic                         flush_i,
   output logic                         dec_valid_o,
   output logic [ADDR_W-1:0]            dec_pc_o,
   output logic [INST_W-1:0]            dec_inst_o,
   input  logic                         dec_ready_i,
   output logic [$clog2(DEPTH+1)-1:0]   count_o,
   output logic                         empty_o,
   output logic                         full_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   typedef struct packed {
      logic [ADDR_W-1:0] pc;
      logic [INST_W-1:0] inst;
   } entry_t;

   entry_t            mem [DEPTH];
   entry_t            head;
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  count;
   logic [ADDR_W-1:0] pc_hold;
   logic              push;
   logic              pop;

   assign count_o       = count;
   assign empty_o       = (count == '0);
   assign full_o        = (count == CNT_W'(DEPTH));
   assign fetch_ready_o = !full_o;
   assign dec_valid_o   = !empty_o;

   assign push = fetch_valid_i & fetch_ready_o;
   assign pop  = dec_valid_o & dec_ready_i;

   assign head       = mem[rd_ptr];
   assign dec_pc_o   = dec_valid_o ? head.pc : pc_hold;
   assign dec_inst_o = dec_valid_o ? head.inst : BUBBLE_INST;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         pc_hold <= '0;
      end else if (flush_i) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         pc_hold <= dec_pc_o;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         // Remember the pc shown to decode so it stays put once the buffer drains.
         pc_hold <= dec_pc_o;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !flush_i) begin
         mem[wr_ptr].pc   <= fetch_pc_i;
         mem[wr_ptr].inst <= fetch_inst_i;
      end
   end

endmodule

// File: tb/tb_if_id_buf.sv
// Directed bench for if_id_buf (DEPTH=4, nonzero bubble so bubble vs. stored data is distinguishable).
module tb_if_id_buf;

   localparam logic [31:0] BUB = 32'h0000_0013;

   logic        clk;
   logic        rst;
   logic        fetch_valid;
   logic [31:0] fetch_pc;
   logic [31:0] fetch_inst;
   logic        fetch_ready;
   logic        flush;
   logic        dec_valid;
   logic [31:0] dec_pc;
   logic [31:0] dec_inst;
   logic        dec_ready;
   logic [2:0]  count;
   logic        empty;
   logic        full;

   int n_cmp;
   int n_err;

   if_id_buf #(
      .ADDR_W(32), .INST_W(32), .DEPTH(4), .BUBBLE_INST(BUB)
   ) dut (
      .clk(clk), .rst(rst),
      .fetch_valid_i(fetch_valid), .fetch_pc_i(fetch_pc), .fetch_inst_i(fetch_inst),
      .fetch_ready_o(fetch_ready), .flush_i(flush),
      .dec_valid_o(dec_valid), .dec_pc_o(dec_pc), .dec_inst_o(dec_inst),
      .dec_ready_i(dec_ready), .count_o(count), .empty_o(empty), .full_o(full)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst);
      fetch_valid = v;
      fetch_pc    = pc;
      fetch_inst  = inst;
   endtask

   task automatic chk_empty(input string tag);
      chk({tag, "_valid"}, 64'(dec_valid), 64'd0);
      chk({tag, "_inst"},  64'(dec_inst), 64'(BUB));
      chk({tag, "_count"}, 64'(count), 64'd0);
      chk({tag, "_ready"}, 64'(fetch_ready), 64'd1);
      chk({tag, "_empty"}, 64'(empty), 64'd1);
      chk({tag, "_full"},  64'(full), 64'd0);
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst = 1'b1;
      flush = 1'b0;
      dec_ready = 1'b0;
      drive(1'b0, 32'h0, 32'h0);
      #2;
      chk_empty("rst_hold");
      chk("rst_pc", 64'(dec_pc), 64'd0);
      tick(); tick();
      rst = 1'b0;
      tick();
      chk_empty("idle");

      // single pass-through
      dec_ready = 1'b1;
      drive(1'b1, 32'h100, 32'h0050_0093);
      tick();
      drive(1'b0, 32'h0, 32'h0);
      chk("pass_valid", 64'(dec_valid), 64'd1);
      chk("pass_pc", 64'(dec_pc), 64'h100);
      chk("pass_inst", 64'(dec_inst), 64'h0050_0093);
      tick();
      chk_empty("pass_drain");
      chk("pass_pc_hold", 64'(dec_pc), 64'h100);

      // fill under stall
      dec_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 32'(4 * i), 32'h1000 + 32'(i));
         tick();
         chk("fill_count", 64'(count), 64'(i + 1));
         chk("fill_head", 64'(dec_pc), 64'h0);
      end
      chk("fill_full", 64'(full), 64'd1);
      chk("fill_ready", 64'(fetch_ready), 64'd0);
      drive(1'b1, 32'h10, 32'h1004);
      tick();
      chk("fifth_count", 64'(count), 64'd4);
      chk("stall_pc", 64'(dec_pc), 64'h0);
      chk("stall_inst", 64'(dec_inst), 64'h1000);

      // full with simultaneous pop: push refused this cycle, accepted next
      dec_ready = 1'b1;
      tick();
      chk("fullpop_count", 64'(count), 64'd3);
      chk("fullpop_head", 64'(dec_pc), 64'h4);
      dec_ready = 1'b0;
      tick();
      drive(1'b0, 32'h0, 32'h0);
      chk("refill_count", 64'(count), 64'd4);
      dec_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("drain_pc", 64'(dec_pc), 64'(32'h4 + 32'(4 * i)));
         chk("drain_inst", 64'(dec_inst), 64'(32'h1001 + 32'(i)));
         tick();
      end
      chk_empty("drain_end");

      // continuous stream across pointer wrap
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, 32'h200 + 32'(4 * i), 32'h2000 + 32'(i));
         tick();
         chk("wrap_valid", 64'(dec_valid), 64'd1);
         chk("wrap_pc", 64'(dec_pc), 64'(32'h200 + 32'(4 * i)));
         chk("wrap_inst", 64'(dec_inst), 64'(32'h2000 + 32'(i)));
         chk("wrap_count", 64'(count), 64'd1);
      end
      drive(1'b0, 32'h0, 32'h0);
      tick();
      chk("wrap_end_count", 64'(count), 64'd0);

      // flush with concurrent push
      dec_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 32'h300 + 32'(4 * i), 32'h3000 + 32'(i));
         tick();
      end
      chk("preflush_count", 64'(count), 64'd3);
      flush = 1'b1;
      drive(1'b1, 32'h3F0, 32'h3FFF);
      tick();
      flush = 1'b0;
      drive(1'b0, 32'h0, 32'h0);
      chk_empty("flush");
      drive(1'b1, 32'h400, 32'h4000);
      tick();
      drive(1'b0, 32'h0, 32'h0);
      chk("postflush_count", 64'(count), 64'd1);
      chk("postflush_pc", 64'(dec_pc), 64'h400);
      chk("postflush_inst", 64'(dec_inst), 64'h4000);

      // asynchronous reset mid-stream
      drive(1'b1, 32'h404, 32'h4001);
      tick();
      drive(1'b1, 32'h408, 32'h4002);
      tick();
      drive(1'b0, 32'h0, 32'h0);
      chk("prerst_count", 64'(count), 64'd3);
      #2;
      rst = 1'b1;
      #1;
      chk_empty("async_rst");
      chk("async_rst_pc", 64'(dec_pc), 64'd0);
      #1;
      rst = 1'b0;
      tick();
      chk_empty("after_rst");
      dec_ready = 1'b1;
      drive(1'b1, 32'h500, 32'h5000);
      tick();
      drive(1'b0, 32'h0, 32'h0);
      chk("rst_resume_pc", 64'(dec_pc), 64'h500);
      chk("rst_resume_inst", 64'(dec_inst), 64'h5000);
      tick();
      chk("rst_resume_count", 64'(count), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
